// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries; head is visible combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [DEPTH];
  logic [IW-1:0] rd_ptr;
  logic [IW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH (a power of two); count tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= EMPTY_ENTRY;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues icache reads under a queue-credit limit and
// buffers the fixed-latency responses for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 4,
  parameter int          IC_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] ic_index,
  output logic        ic_en,
  input  logic [31:0] ic_rdata,
  input  logic        ic_rvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [31:0]           pc;
  logic [IC_LATENCY-1:0] sh_valid;
  logic [31:0]           sh_pc [IC_LATENCY];
  logic [IC_LATENCY-1:0] req_track;
  logic [31:0]           occupancy;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         fq_count;
  logic                  fq_full;
  logic                  fq_empty;
  fetch_entry_t          fq_head;
  fetch_entry_t          push_entry;

  // Queued plus in-flight work must fit in the queue; pops this cycle earn no credit.
  always_comb begin
    occupancy = 32'(fq_count);
    for (int i = 0; i < IC_LATENCY; i++) begin
      occupancy = occupancy + 32'(sh_valid[i]);
    end
    credit_ok  = (occupancy < 32'(FQ_DEPTH));
    ic_en      = rst_n && (redirect_valid || credit_ok);
    ic_index   = redirect_valid ? redirect_pc[31:2] : pc[31:2];
    push       = ic_rvalid && sh_valid[IC_LATENCY-1] && !redirect_valid;
    pop        = out_valid && out_ready && !redirect_valid;
    push_entry = '{pc: sh_pc[IC_LATENCY-1], instr: ic_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc + PC_INC;
    end else if (ic_en) begin
      pc <= pc + PC_INC;
    end
  end

  // Stage 0 always captures this cycle's request, so a redirect target survives its own squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid <= '0;
      for (int i = 0; i < IC_LATENCY; i++) begin
        sh_pc[i] <= '0;
      end
    end else begin
      sh_valid[0] <= ic_en;
      sh_pc[0]    <= {ic_index, 2'b00};
      for (int i = 1; i < IC_LATENCY; i++) begin
        sh_valid[i] <= sh_valid[i-1] && !redirect_valid;
        sh_pc[i]    <= sh_pc[i-1];
      end
    end
  end

  // Mirrors what the icache actually saw, ignoring squashes and reset, so responses can be cross-checked.
  always_ff @(posedge clk) begin
    req_track[0] <= ic_en;
    for (int i = 1; i < IC_LATENCY; i++) begin
      req_track[i] <= req_track[i-1];
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (fq_count),
    .head     (fq_head),
    .full     (fq_full),
    .empty    (fq_empty)
  );

  assign out_valid = !fq_empty;
  assign out_pc    = fq_head.pc;
  assign out_instr = fq_head.instr;

  a_rvalid_matches_request: assert property (
    @(posedge clk) disable iff (!rst_n) ic_rvalid == req_track[IC_LATENCY-1]);

  a_redirect_aligned: assert property (
    @(posedge clk) disable iff (!rst_n) redirect_valid |-> (redirect_pc[1:0] == 2'b00));

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && fq_full));

  a_head_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !redirect_valid) |=>
      (out_valid && $stable(out_pc) && $stable(out_instr)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 2-cycle ROM icache model (mem[i] = i).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] ic_index;
  logic        ic_en;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FQ_DEPTH  (4),
    .IC_LATENCY(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ic_index      (ic_index),
    .ic_en         (ic_en),
    .ic_rdata      (ic_rdata),
    .ic_rvalid     (ic_rvalid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  always #5 clk = ~clk;

  // Icache model: free-running two-stage pipe, unaffected by the DUT reset.
  logic        p1_v = 1'b0;
  logic        p2_v = 1'b0;
  logic [29:0] p1_i = '0;
  logic [29:0] p2_i = '0;

  always @(posedge clk) begin
    p1_v <= ic_en;
    p1_i <= ic_index;
    p2_v <= p1_v;
    p2_i <= p1_i;
  end

  assign ic_rvalid = p2_v;
  assign ic_rdata  = {2'b00, p2_i};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    #1;
  endtask

  task automatic resetDut(input logic rdy);
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic waitPc(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 20) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_pc"}, out_pc, exp_pc);
    checkOutput({tag, "_instr"}, out_instr, exp_instr);
    applyStimulus(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ic_en", 32'(ic_en), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0000_0013);

    // Test 1: first fetch latency and bubble-free streaming.
    resetDut(1'b1);
    checkOutput("t1_c0_ic_en", 32'(ic_en), 32'd1);
    checkOutput("t1_c0_index", 32'(ic_index), 32'h0);
    checkOutput("t1_c0_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_c1_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_c2_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("t1_c%0d_valid", k + 3), 32'(out_valid), 32'd1);
      checkOutput($sformatf("t1_c%0d_pc", k + 3), out_pc, 32'(4 * k));
      checkOutput($sformatf("t1_c%0d_instr", k + 3), out_instr, 32'(k));
    end

    // Test 2: decode stalled, credit limit stops issue after four requests.
    resetDut(1'b0);
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("t2_c%0d_ic_en", c), 32'(ic_en), (c < 4) ? 32'd1 : 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0);
    end
    checkOutput("t2_count", 32'(dut.fq_count), 32'd4);
    checkOutput("t2_head_pc", out_pc, 32'h0);
    for (int k = 0; k < 5; k++) begin
      waitPc($sformatf("t2_e%0d", k), 32'(4 * k), 32'(k));
    end

    // Test 3: redirect while 0x8 and 0xC are in flight.
    resetDut(1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_c3_pc", out_pc, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1);
    checkOutput("t3_redir_ic_en", 32'(ic_en), 32'd1);
    checkOutput("t3_redir_index", 32'(ic_index), 32'h10);
    checkOutput("t3_redir_head", out_pc, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_r1_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_r2_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_r3_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_r3_pc", out_pc, 32'h40);
    checkOutput("t3_r3_instr", out_instr, 32'h10);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_r4_pc", out_pc, 32'h44);
    checkOutput("t3_r4_instr", out_instr, 32'h11);

    // Test 4: redirect with a full queue and decode stalled.
    resetDut(1'b0);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("t4_full_valid", 32'(out_valid), 32'd1);
    checkOutput("t4_redir_ic_en", 32'(ic_en), 32'd1);
    checkOutput("t4_redir_index", 32'(ic_index), 32'h40);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_flushed_valid", 32'(out_valid), 32'd0);
    waitPc("t4_e0", 32'h100, 32'h40);
    waitPc("t4_e1", 32'h104, 32'h41);

    // Test 5: PC wraps past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    checkOutput("t5_redir_index", 32'(ic_index), 32'h3FFF_FFFE);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitPc("t5_e0", 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    waitPc("t5_e1", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    waitPc("t5_e2", 32'h0000_0000, 32'h0);
    waitPc("t5_e3", 32'h0000_0004, 32'h1);

    // Test 6: asynchronous reset mid-stream, stale icache response afterwards.
    resetDut(1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_ic_en", 32'(ic_en), 32'd0);
    checkOutput("t6_rst_out_pc", out_pc, 32'h0);
    checkOutput("t6_rst_out_instr", out_instr, 32'h0000_0013);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("t6_stale_rvalid", 32'(ic_rvalid), 32'd1);
    checkOutput("t6_c0_ic_en", 32'(ic_en), 32'd1);
    checkOutput("t6_c0_index", 32'(ic_index), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_c1_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_c2_valid", 32'(out_valid), 32'd0);
    waitPc("t6_e0", 32'h0, 32'h0);
    waitPc("t6_e1", 32'h4, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
